// File: rtl/wb_bus_pkg.sv
// Shared types, defaults and helpers for the Wishbone bus controller.
package wb_bus_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Word returned to the master when a transfer is terminated with an error.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Default number of REQ cycles allowed before a transfer is declared hung.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Counter width able to hold any count up to the timeout value.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(TIMEOUT_DEFAULT);

  // Slave index field of an address; n_slv is a power of two.
  function automatic logic [31:0] slv_index(input logic [31:0] adr,
                                            input int unsigned sel_lsb,
                                            input int unsigned n_slv);
    return (adr >> sel_lsb) & (n_slv - 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clear / enable / expire counter. expired is high in the enabled cycle in
// which the count equals LIMIT-1, i.e. the LIMIT-th enabled cycle.
module wb_timeout_cnt #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  assign expired = en && (cnt == W'(LIMIT - 1));

  // Count enabled cycles; clear has priority so every window starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_bus_ctrl.sv
// Wishbone bus controller: decodes master cycles to one of N_SLV windows,
// runs one transfer at a time and terminates hung or unmapped transfers
// with ERR_DATA, a sticky error flag, the failing address and an IRQ pulse.
//
// Handshake: the master request is taken when wbs_cyc_i & wbs_stb_i are high
// in IDLE; the selected slave sees cyc/stb until it acks; wbs_ack_o is high
// for exactly one cycle in RESP; a mandatory IDLE cycle follows every RESP.
module wb_bus_ctrl
  import wb_bus_pkg::*;
#(
  parameter int unsigned N_SLV    = 4,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter int unsigned SEL_LSB  = 16,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [N_SLV-1:0]      s_cyc_o,
  output logic [N_SLV-1:0]      s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  input  logic [N_SLV*32-1:0]   s_dat_i,
  input  logic [N_SLV-1:0]      s_ack_i,
  input  logic                  err_clr_i,
  output logic                  err_o,
  output logic [31:0]           err_adr_o,
  output logic                  irq_o
);

  localparam int unsigned SW = $clog2(N_SLV);
  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q;
  logic [31:0]   adr_q;
  logic          resp_err_q;
  logic          mapped, sel_ack, expired;
  logic [31:0]   sel_dat;
  logic          accept_map, accept_unmap, done_ok, done_err;

  assign mapped  = (wbs_adr_i[31:24] == BASE[31:24]);
  assign sel_ack = s_ack_i[sel_q];
  assign sel_dat = s_dat_i[32*sel_q +: 32];

  // Only the latched slave sees cyc/stb, and only while in REQ.
  assign s_stb_o   = (state_q == ST_REQ) ? (N_SLV'(1) << sel_q) : '0;
  assign s_cyc_o   = s_stb_o;
  assign wbs_ack_o = (state_q == ST_RESP);
  assign irq_o     = (state_q == ST_RESP) && resp_err_q;

  wb_timeout_cnt #(
    .W     (CW),
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .clr     (state_q != ST_REQ),
    .en      (state_q == ST_REQ),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state and transfer events; abort beats ack, ack beats timeout.
  always_comb begin
    state_d      = state_q;
    accept_map   = 1'b0;
    accept_unmap = 1'b0;
    done_ok      = 1'b0;
    done_err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (mapped) begin
            accept_map = 1'b1;
            state_d    = ST_REQ;
          end else begin
            accept_unmap = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          done_ok = 1'b1;
          state_d = ST_RESP;
        end else if (expired) begin
          done_err = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, response data and the sticky error record.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sel_q      <= '0;
      adr_q      <= '0;
      s_we_o     <= 1'b0;
      s_sel_o    <= '0;
      s_adr_o    <= '0;
      s_dat_o    <= '0;
      wbs_dat_o  <= '0;
      resp_err_q <= 1'b0;
      err_o      <= 1'b0;
      err_adr_o  <= '0;
    end else begin
      resp_err_q <= accept_unmap || done_err;
      if (accept_map || accept_unmap) adr_q <= wbs_adr_i;
      if (accept_map) begin
        sel_q   <= SW'(slv_index(wbs_adr_i, SEL_LSB, N_SLV));
        s_we_o  <= wbs_we_i;
        s_sel_o <= wbs_sel_i;
        s_adr_o <= wbs_adr_i;
        s_dat_o <= wbs_dat_i;
      end
      if (done_ok) wbs_dat_o <= sel_dat;
      // A new error outranks a simultaneous clear.
      if (accept_unmap || done_err) begin
        wbs_dat_o <= ERR_DATA;
        err_o     <= 1'b1;
        err_adr_o <= accept_unmap ? wbs_adr_i : adr_q;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule
